// File: rtl/debug_mon_pkg.sv
// debug_mon_pkg: shared types and constants for the debug memory accessor
package debug_mon_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  localparam int JDO_RD_NOW_BIT = 34;
  localparam int JDO_AUTOINC_BIT = 35;
  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/debug_mon_mem_access_if.sv
// debug_mon_mem_access_if: Avalon-MM master bus used by the debug memory accessor
interface debug_mon_mem_access_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] address;
  logic read;
  logic write;
  logic [31:0] writedata;
  logic [3:0] byteenable;
  logic [31:0] readdata;
  logic waitrequest;
  logic [1:0] response;
  modport master(output address, read, write, writedata, byteenable, input readdata, waitrequest, response);
  modport slave(input address, read, write, writedata, byteenable, output readdata, waitrequest, response);
endinterface

// File: rtl/debug_mon_timeout.sv
// debug_mon_timeout: stall counter that flags expiry after TIMEOUT_CYCLES stalled cycles
module debug_mon_timeout #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + W'(1);
  assign expired = cnt == W'(TIMEOUT_CYCLES);
endmodule

// File: rtl/debug_mon_mem_access.sv
// debug_mon_mem_access: runs single debug reads/writes on Avalon-MM for the JTAG debug slave
module debug_mon_mem_access
  import debug_mon_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [37:0] jdo,
  input  logic take_action_ocimem_a,
  input  logic take_action_ocimem_b,
  input  logic take_no_action_ocimem_a,
  debug_mon_mem_access_if.master avm,
  output logic [31:0] MonDReg,
  output logic monitor_ready,
  output logic monitor_error,
  output logic debug_busy
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n, mon_n;
  logic autoinc_q, autoinc_n, overrun_q, overrun_n, rdy_n, err_n;
  logic idle, any_take, extra_take, expired, done, bus_ok;
  logic unused_jdo;
  assign unused_jdo = ^jdo;
  assign idle = state == IDLE;
  assign any_take = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign extra_take = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a)) |
                      (take_action_ocimem_b & take_no_action_ocimem_a);
  assign bus_ok = !avm.waitrequest && avm.response == RESP_OKAY;
  assign done = !idle && (!avm.waitrequest || expired);
  debug_mon_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .reset_n(reset_n),
    .clr(idle),
    .en(avm.waitrequest),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    addr_n = addr_q;
    autoinc_n = autoinc_q;
    wdata_n = wdata_q;
    overrun_n = overrun_q;
    mon_n = MonDReg;
    rdy_n = monitor_ready;
    err_n = monitor_error;
    if (idle) begin
      if (take_action_ocimem_a) begin
        addr_n = {jdo[ADDR_W-1:2], 2'b00};
        autoinc_n = jdo[JDO_AUTOINC_BIT];
        state_n = jdo[JDO_RD_NOW_BIT] ? READ : IDLE;
        rdy_n = !jdo[JDO_RD_NOW_BIT];
        err_n = 1'b0;
        overrun_n = extra_take;
      end else if (take_action_ocimem_b) begin
        wdata_n = jdo[31:0];
        state_n = WRITE;
        rdy_n = 1'b0;
        err_n = 1'b0;
        overrun_n = extra_take;
      end else if (take_no_action_ocimem_a) begin
        state_n = READ;
        rdy_n = 1'b0;
        err_n = 1'b0;
        overrun_n = 1'b0;
      end
    end else begin
      // a pulse landing in the completion cycle still counts against this command
      overrun_n = overrun_q | any_take;
      if (done) begin
        state_n = IDLE;
        rdy_n = 1'b1;
        err_n = !bus_ok | overrun_n;
        mon_n = (bus_ok && state == READ) ? avm.readdata : MonDReg;
        addr_n = (bus_ok && autoinc_q) ? addr_q + ADDR_W'(4) : addr_q;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      addr_q <= '0;
      autoinc_q <= 1'b0;
      wdata_q <= '0;
      overrun_q <= 1'b0;
      MonDReg <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      state <= state_n;
      addr_q <= addr_n;
      autoinc_q <= autoinc_n;
      wdata_q <= wdata_n;
      overrun_q <= overrun_n;
      MonDReg <= mon_n;
      monitor_ready <= rdy_n;
      monitor_error <= err_n;
    end
  assign avm.read = state == READ;
  assign avm.write = state == WRITE;
  assign avm.address = addr_q;
  assign avm.writedata = wdata_q;
  assign avm.byteenable = 4'hF;
  assign debug_busy = !idle;
endmodule

// File: tb/tb_debug_mon_mem_access.sv
// tb_debug_mon_mem_access: randomized transaction-level check of the debug memory accessor
module tb_debug_mon_mem_access;
  import debug_mon_pkg::*;
  localparam int T = 15;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic ta = 1'b0, tkb = 1'b0, tn = 1'b0;
  logic [31:0] mon;
  logic rdy, err, busy;
  debug_mon_mem_access_if #(.ADDR_W(32)) avm ();
  debug_mon_mem_access #(.ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .jdo(jdo),
    .take_action_ocimem_a(ta),
    .take_action_ocimem_b(tkb),
    .take_no_action_ocimem_a(tn),
    .avm(avm),
    .MonDReg(mon),
    .monitor_ready(rdy),
    .monitor_error(err),
    .debug_busy(busy)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0, strobe_cnt = 0;
  logic chk_en = 1'b0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0;
  logic exp_rd, exp_wr, exp_busy, exp_rdy, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_mon;
  logic [31:0] m_addr, m_wdata, m_mon;
  logic m_auto, m_rdy, m_err;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask
  always @(negedge clk) begin
    if (avm.read) last_rd_addr = avm.address;
    if (avm.write) last_wr_addr = avm.address;
    if (avm.read || avm.write) strobe_cnt++;
    if (chk_en) begin
      chk("avm_read", 32'(avm.read), 32'(exp_rd));
      chk("avm_write", 32'(avm.write), 32'(exp_wr));
      chk("debug_busy", 32'(busy), 32'(exp_busy));
      chk("monitor_ready", 32'(rdy), 32'(exp_rdy));
      chk("monitor_error", 32'(err), 32'(exp_err));
      chk("MonDReg", mon, exp_mon);
      if (exp_rd || exp_wr) begin
        chk("avm_address", avm.address, exp_addr);
        chk("avm_byteenable", 32'(avm.byteenable), 32'hF);
      end
      if (exp_wr) chk("avm_writedata", avm.writedata, exp_wdata);
    end
  end
  task automatic model_reset();
    m_addr = '0; m_wdata = '0; m_mon = '0; m_auto = 1'b0; m_rdy = 1'b0; m_err = 1'b0;
  endtask
  task automatic idle_exp();
    exp_rd = 1'b0; exp_wr = 1'b0; exp_busy = 1'b0; exp_rdy = m_rdy; exp_err = m_err;
    exp_mon = m_mon; exp_addr = m_addr; exp_wdata = m_wdata;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    avm.waitrequest = 1'($urandom);
    avm.readdata = $urandom;
    avm.response = 2'($urandom);
  endtask
  // kind: 0 = load address, 1 = write, 2 = re-read; stall = cycles waitrequest stays high
  task automatic run_cmd(input int kind, input logic [37:0] j, input int stall, input logic [1:0] resp,
                         input logic [31:0] rdata, input int ovr_at, input int ovr_kind, input bit extra);
    bit starts, is_read, ovr, done, tmo, ok;
    jdo = j;
    ta = kind == 0; tkb = kind == 1; tn = kind == 2;
    if (extra && kind == 0) begin tkb = 1'b1; tn = 1'($urandom); end
    else if (extra && kind == 1) tn = 1'b1;
    ovr = extra && kind != 2;
    step();
    ta = 1'b0; tkb = 1'b0; tn = 1'b0; jdo = {6'($urandom), $urandom};
    starts = kind != 0 || j[JDO_RD_NOW_BIT];
    is_read = kind != 1;
    if (kind == 0) begin m_addr = {j[31:2], 2'b00}; m_auto = j[JDO_AUTOINC_BIT]; end
    if (kind == 1) m_wdata = j[31:0];
    m_rdy = !starts;
    m_err = 1'b0;
    if (!starts) begin idle_exp(); return; end
    for (int k = 0; k <= T; k++) begin
      avm.waitrequest = k < stall;
      if (k >= stall) begin avm.readdata = rdata; avm.response = resp; end
      exp_rd = is_read; exp_wr = !is_read; exp_busy = 1'b1; exp_rdy = 1'b0; exp_err = 1'b0;
      exp_mon = m_mon; exp_addr = m_addr; exp_wdata = m_wdata;
      if (k == ovr_at) begin
        ta = ovr_kind == 0; tkb = ovr_kind == 1; tn = ovr_kind == 2; ovr = 1'b1;
      end
      done = k >= stall || k == T;
      tmo = k < stall;
      step();
      ta = 1'b0; tkb = 1'b0; tn = 1'b0;
      if (done) begin
        ok = !tmo && resp == RESP_OKAY;
        m_rdy = 1'b1;
        m_err = !ok || ovr;
        if (ok && is_read) m_mon = rdata;
        if (ok && m_auto) m_addr = m_addr + 32'd4;
        idle_exp();
        break;
      end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int s0, kind, stall, ovr_at;
    logic [37:0] j;
    logic [1:0] resp;
    logic [31:0] wa [3];
    wa[0] = 32'hFFFF_FFFC; wa[1] = 32'h0; wa[2] = 32'h4;
    model_reset();
    idle_exp();
    avm.waitrequest = 1'b0; avm.readdata = '0; avm.response = '0;
    chk_en = 1'b1;
    repeat (3) step();
    chk("rst_read", 32'(avm.read), 32'h0);
    chk("rst_write", 32'(avm.write), 32'h0);
    chk("rst_address", avm.address, 32'h0);
    chk("rst_writedata", avm.writedata, 32'h0);
    chk("rst_ready", 32'(rdy), 32'h0);
    reset_n = 1'b1;
    step();
    // single read, no wait
    j = '0; j[JDO_RD_NOW_BIT] = 1'b1; j[31:0] = 32'h0000_1000;
    s0 = strobe_cnt;
    run_cmd(0, j, 0, 2'b00, 32'hCAFE_F00D, -1, 0, 1'b0);
    chk("t1_strobes", 32'(strobe_cnt - s0), 32'd1);
    chk("t1_addr", last_rd_addr, 32'h0000_1000);
    chk("t1_mon", mon, 32'hCAFE_F00D);
    chk("t1_ready", 32'(rdy), 32'h1);
    // autoinc writes wrapping through the top of the address space
    j = '0; j[JDO_AUTOINC_BIT] = 1'b1; j[31:0] = 32'hFFFF_FFFC;
    run_cmd(0, j, 0, 2'b00, 32'h0, -1, 0, 1'b0);
    chk("wrap_load_ready", 32'(rdy), 32'h1);
    for (int d = 1; d <= 3; d++) begin
      run_cmd(1, {6'b0, 32'(d)}, $urandom_range(0, 3), 2'b00, 32'h0, -1, 0, 1'b0);
      chk("wrap_addr", last_wr_addr, wa[d-1]);
      chk("wrap_err", 32'(err), 32'h0);
    end
    chk("wrap_model_addr", m_addr, 32'h8);
    // timeout
    s0 = strobe_cnt;
    run_cmd(2, '0, 100, 2'b00, 32'h1234_5678, -1, 0, 1'b0);
    chk("tmo_strobes", 32'(strobe_cnt - s0), 32'd16);
    chk("tmo_ready", 32'(rdy), 32'h1);
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_mon", mon, 32'hCAFE_F00D);
    run_cmd(2, '0, 0, 2'b00, 32'h0BAD_BEEF, -1, 0, 1'b0);
    chk("tmo_addr_kept", last_rd_addr, 32'h8);
    // write with error response does not advance the address
    run_cmd(1, {6'b0, 32'hDEAD_0001}, 2, 2'b10, 32'h0, -1, 0, 1'b0);
    chk("werr_err", 32'(err), 32'h1);
    chk("werr_addr", last_wr_addr, 32'hC);
    run_cmd(2, '0, 0, 2'b00, 32'h600D_0001, -1, 0, 1'b0);
    chk("werr_addr_kept", last_rd_addr, 32'hC);
    // write pulse during a stalled read
    run_cmd(2, '0, 5, 2'b00, 32'hA5A5_0005, 2, 1, 1'b0);
    chk("ovr_mon", mon, 32'hA5A5_0005);
    chk("ovr_err", 32'(err), 32'h1);
    // reset in the middle of a stalled write
    jdo = {6'b0, 32'h5555_AAAA}; tkb = 1'b1;
    step();
    tkb = 1'b0;
    m_wdata = 32'h5555_AAAA; m_rdy = 1'b0; m_err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      avm.waitrequest = 1'b1;
      exp_rd = 1'b0; exp_wr = 1'b1; exp_busy = 1'b1; exp_rdy = 1'b0; exp_err = 1'b0;
      exp_mon = m_mon; exp_addr = m_addr; exp_wdata = m_wdata;
      if (k < 2) step();
    end
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_write", 32'(avm.write), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_mon", mon, 32'h0);
    chk("rst_mid_err", 32'(err), 32'h0);
    chk("rst_mid_address", avm.address, 32'h0);
    model_reset();
    idle_exp();
    step();
    step();
    reset_n = 1'b1;
    step();
    j = '0; j[JDO_RD_NOW_BIT] = 1'b1; j[31:0] = 32'h0000_0040;
    run_cmd(0, j, 1, 2'b00, 32'h1122_3344, -1, 0, 1'b0);
    chk("post_rst_mon", mon, 32'h1122_3344);
    chk("post_rst_addr", last_rd_addr, 32'h40);
    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 2);
      j = {6'($urandom), $urandom};
      stall = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      ovr_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, stall < T ? stall : T) : -1;
      run_cmd(kind, j, stall, resp, $urandom, ovr_at, $urandom_range(0, 2), $urandom_range(0, 5) == 0);
      repeat ($urandom_range(0, 2)) step();
    end
    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/debug_mon_mem_access.md
# debug_mon_mem_access

Sysclk-domain debug memory accessor sitting directly downstream of the CPU debug-slave wrapper. It consumes the synchronised `jdo` word and the `take_action_ocimem_*` / `take_no_action_ocimem_a` pulses, and runs single Avalon-MM master reads or writes on the debug bus. It returns results to the wrapper through `MonDReg`, `monitor_ready` and `monitor_error`, which feed the JTAG scan chain.

## Interface
- ADDR_W, 32, Avalon byte-address width (≤32); address taken from `jdo[ADDR_W-1:0]`.
- TIMEOUT_CYCLES, 1023, maximum cycles a request may stall on `avm_waitrequest` before it is aborted.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  reset; asynchronous, active-low.
- jdo  in  38  command payload from the debug-slave wrapper, valid in the cycle a take pulse is high.
- take_action_ocimem_a  in  1  load-address command.
- take_action_ocimem_b  in  1  write command.
- take_no_action_ocimem_a  in  1  re-read command at the current address.
- avm_address  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- avm_read / avm_write  out  1  Avalon request strobes.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  constant 4'hF.
- avm_readdata  in  32  read data, valid when `avm_read && !avm_waitrequest`.
- avm_waitrequest  in  1  slave stall.
- avm_response  in  2  2'b00 OK; any other value is an error.
- MonDReg  out  32  last successfully read word.
- monitor_ready  out  1  the last command has completed.
- monitor_error  out  1  the last command failed or overran.
- debug_busy  out  1  state ≠ IDLE.

## Operation
- jdo fields:
  - `[ADDR_W-1:0]` is the address/data field.
  - `jdo[34]` is RD_NOW.
  - `jdo[35]` is AUTOINC.
  - `jdo[37:36]` and the remaining bits are ignored.
- Registers:
  - addr_q is the current word address.
  - autoinc_q is the latched AUTOINC bit.
  - wdata_q holds write data.
  - overrun_q is the overrun flag.
- take_action_ocimem_a:
  - addr_q ← `{jdo[ADDR_W-1:2],2'b00}` and autoinc_q ← `jdo[35]`.
  - If `jdo[34]` is set, start a READ.
  - Otherwise, set monitor_ready=1 and monitor_error=0 in the next cycle.
- take_action_ocimem_b: wdata_q ← `jdo[31:0]`, then start a WRITE.
- take_no_action_ocimem_a: start a READ at addr_q.
- Starting a command clears monitor_ready, monitor_error and overrun_q.
- FSM states:
  - IDLE → READ on a read command; IDLE → WRITE on a write command.
  - READ/WRITE → IDLE when `!avm_waitrequest`, or when the timeout counter reaches TIMEOUT_CYCLES.
- Read completion, response OK: MonDReg ← avm_readdata, monitor_ready ← 1.
- Write completion, response OK: monitor_ready ← 1.
- Completion with a non-OK response:
  - monitor_ready ← 1 and monitor_error ← 1.
  - MonDReg is unchanged.
  - addr_q does not increment.
- Timeout: same as a non-OK completion, and the strobe drops in the abort cycle.
- Successful completion with autoinc_q set: addr_q ← addr_q + 4, modulo 2^ADDR_W. 0xFFFF_FFFC wraps to 0.
- Any take pulse while not in IDLE:
  - The command is dropped and overrun_q ← 1.
  - At completion, monitor_error ← (response error | timeout | overrun_q).
- Simultaneous pulses are prioritised a > b > no_action_a. Each lower-priority pulse is dropped and counts as an overrun.

## Timing
- Reset values:
  - All avm_* strobes are 0; avm_address = 0; avm_writedata = 0.
  - MonDReg = 0, monitor_ready = 0, monitor_error = 0, debug_busy = 0.
  - FSM is IDLE; all internal registers are 0.
- Request strobes are registered. A command pulse in cycle N asserts the strobe in N+1.
- If `avm_waitrequest` is low in N+1, results are visible in N+2 and the strobe is low in N+2. Minimum latency is 2 cycles.
- Address/data/strobes are held stable while `avm_waitrequest` is high.
- Timeout counter:
  - Cleared on entry to READ/WRITE.
  - Increments every stalled cycle.
  - Abort happens in the cycle the count reaches TIMEOUT_CYCLES, so the strobe is high for TIMEOUT_CYCLES+1 cycles at most.
- A load-address command without RD_NOW asserts monitor_ready in N+1.
- A reset assertion mid-transaction clears the strobes asynchronously. This is accepted because the debug bus shares the system reset.

## Structure
- Package `debug_mon_pkg`:
  - state enum {IDLE, READ, WRITE}.
  - JDO_RD_NOW_BIT=34 and JDO_AUTOINC_BIT=35.
  - Response code constant RESP_OKAY=2'b00.
- Sub-module `debug_mon_timeout`:
  - Loadable stall counter with `clr`, `en`, and `expired` outputs.
  - Parameterised by TIMEOUT_CYCLES; counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- ocimem_a with jdo = {RD_NOW=1, addr 0x0000_1000}, slave returns 0xCAFE_F00D with no wait:
  - avm_read high in N+1 only, at address 0x1000.
  - MonDReg = 0xCAFE_F00D and monitor_ready = 1 in N+2.
- AUTOINC=1 at address 0xFFFF_FFFC, three ocimem_b writes with data 1, 2, 3:
  - Writes land at 0xFFFF_FFFC, 0x0, 0x4.
  - monitor_error = 0 throughout.
- Read with avm_waitrequest held high, TIMEOUT_CYCLES=15:
  - Strobe high for exactly 16 cycles, then drops.
  - monitor_ready = 1, monitor_error = 1.
  - MonDReg and addr_q unchanged.
- Write completing with avm_response = 2'b10: monitor_error = 1 and the address is not incremented.
- ocimem_b pulsed during a 5-cycle stalled read: read completes with correct MonDReg, monitor_error = 1, and no write is issued.
- reset_n asserted in the middle of a stalled write:
  - Strobes drop immediately.
  - All outputs return to reset values.
  - A subsequent read works normally.
